// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
// PC source selects and sequencer state encodings.
package pipeline_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;
    localparam logic [1:0] PC_SEL_EXC = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_VECTOR = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the ID sources and the EX load target.
// Purely combinational; register $0 never matches.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    // Source match against a non-zero load destination
    always_comb begin
        rs_hit   = (if_id_rs == id_ex_rt);
        rt_hit   = id_uses_rt && (if_id_rt == id_ex_rt);
        load_use = id_ex_memread && (id_ex_rt != 5'd0) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges load-use, HI/LO occupancy, redirects, dmem wait and irq drain.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int IRQ_DRAIN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] id_ex_rt,
    input  logic       id_ex_memread,
    input  logic       id_md_op,
    input  logic       id_reads_hilo,
    input  logic       id_jump,
    input  logic       ex_branch_taken,
    input  logic       dmem_wait,
    input  logic       irq,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       ex_mem_hold,
    output logic       md_busy,
    output logic [1:0] pc_sel,
    output logic       irq_ack
);

    localparam int MW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam int DW = (IRQ_DRAIN > 1) ? $clog2(IRQ_DRAIN) : 1;
    localparam logic [MW-1:0] MD_LOAD = MW'(MD_LATENCY - 1);
    localparam logic [DW-1:0] DR_LOAD = DW'(IRQ_DRAIN - 1);

    ctrl_state_t   state;
    ctrl_state_t   state_nxt;
    logic [MW-1:0] md_cnt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_nxt;
    logic          md_issue;
    logic          load_use;
    logic          md_pend;
    logic          stall;

    load_use_detect u_lud (
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .id_uses_rt    (id_uses_rt),
        .load_use      (load_use)
    );

    // Hazard summary used by the RUN-state priority chain
    always_comb begin
        md_pend = (md_cnt != '0);
        stall   = load_use || (md_pend && (id_reads_hilo || id_md_op));
    end

    // Control outputs and next-state, highest priority first
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        md_busy      = md_pend;
        pc_sel       = PC_SEL_SEQ;
        irq_ack      = 1'b0;
        md_issue     = 1'b0;
        state_nxt    = state;
        drain_nxt    = drain_cnt;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            md_busy      = 1'b0;
        end else if (dmem_wait) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        pc_sel       = PC_SEL_BR;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (stall) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else begin
                        md_issue = id_md_op;
                        if (id_jump) begin
                            pc_sel      = PC_SEL_JMP;
                            if_id_flush = 1'b1;
                        end
                    end
                    if (irq && !ex_branch_taken && !id_jump) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = DR_LOAD;
                    end
                end
                ST_DRAIN: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (drain_cnt != '0) begin
                        drain_nxt = drain_cnt - 1'b1;
                    end else if (!md_pend) begin
                        state_nxt = ST_VECTOR;
                    end
                end
                ST_VECTOR: begin
                    pc_sel       = PC_SEL_EXC;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    irq_ack      = 1'b1;
                    state_nxt    = ST_RUN;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Sequencer state, HI/LO occupancy and drain counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            md_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (md_issue) begin
                md_cnt <= MD_LOAD;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then random traffic.
// Expected outputs come from a timestamp/phase reference model.
module tb_pipeline_ctrl;

    localparam int MD_LATENCY = 4;
    localparam int IRQ_DRAIN  = 3;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ex_rt;
        logic       memread;
        logic       md_op;
        logic       hilo;
        logic       jump;
        logic       br;
        logic       dwait;
        logic       irq;
    } stim_t;

    typedef struct packed {
        logic       pc_write;
        logic       if_id_write;
        logic       if_id_flush;
        logic       id_ex_bubble;
        logic       ex_mem_hold;
        logic       md_busy;
        logic [1:0] pc_sel;
        logic       irq_ack;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_uses_rt;
    logic [4:0] id_ex_rt;
    logic       id_ex_memread;
    logic       id_md_op;
    logic       id_reads_hilo;
    logic       id_jump;
    logic       ex_branch_taken;
    logic       dmem_wait;
    logic       irq;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_mem_hold;
    logic       md_busy;
    logic [1:0] pc_sel;
    logic       irq_ack;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sq[$];

    // Reference model state
    longint cyc      = 0;
    longint md_ready = 0;
    bit     in_drain = 0;
    bit     in_vec   = 0;
    int     drained  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MD_LATENCY (MD_LATENCY),
        .IRQ_DRAIN  (IRQ_DRAIN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_ex_rt        (id_ex_rt),
        .id_ex_memread   (id_ex_memread),
        .id_md_op        (id_md_op),
        .id_reads_hilo   (id_reads_hilo),
        .id_jump         (id_jump),
        .ex_branch_taken (ex_branch_taken),
        .dmem_wait       (dmem_wait),
        .irq             (irq),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_hold     (ex_mem_hold),
        .md_busy         (md_busy),
        .pc_sel          (pc_sel),
        .irq_ack         (irq_ack)
    );

    function automatic out_t mk(bit pw, bit iw, bit fl, bit bb, bit hd,
                                bit busy, logic [1:0] sel, bit ack);
        out_t o;
        o.pc_write     = pw;
        o.if_id_write  = iw;
        o.if_id_flush  = fl;
        o.id_ex_bubble = bb;
        o.ex_mem_hold  = hd;
        o.md_busy      = busy;
        o.pc_sel       = sel;
        o.irq_ack      = ack;
        return o;
    endfunction

    // Expected response for one cycle; advances the model afterwards
    task automatic model(input stim_t s, output out_t e);
        bit busy;
        bit lu;
        bit stl;
        busy = (cyc < md_ready);
        lu   = s.memread && s.ex_rt != 0 &&
               (s.rs == s.ex_rt || (s.uses_rt && s.rt == s.ex_rt));
        stl  = lu || (busy && (s.hilo || s.md_op));
        if (s.reset) begin
            e        = mk(0, 0, 1, 1, 0, 0, 2'b00, 0);
            in_drain = 0;
            in_vec   = 0;
            drained  = 0;
            md_ready = 0;
            cyc      = -1;
        end else if (s.dwait) begin
            e = mk(0, 0, 0, 0, 1, busy, 2'b00, 0);
            if (!in_drain && !in_vec && s.irq) begin
                e = e;
            end
        end else if (in_vec) begin
            e      = mk(1, 0, 1, 1, 0, busy, 2'b11, 1);
            e.if_id_write = 1;
            in_vec = 0;
        end else if (in_drain) begin
            e = mk(0, 0, 0, 1, 0, busy, 2'b00, 0);
            if (drained >= IRQ_DRAIN - 1 && !busy) begin
                in_drain = 0;
                in_vec   = 1;
            end
            drained++;
        end else begin
            if (s.br)
                e = mk(1, 1, 1, 1, 0, busy, 2'b01, 0);
            else if (stl)
                e = mk(0, 0, 0, 1, 0, busy, 2'b00, 0);
            else if (s.jump)
                e = mk(1, 1, 1, 0, 0, busy, 2'b10, 0);
            else
                e = mk(1, 1, 0, 0, 0, busy, 2'b00, 0);
            if (!s.br && !stl && s.md_op)
                md_ready = cyc + MD_LATENCY;
            if (s.irq && !s.br && !s.jump) begin
                in_drain = 1;
                drained  = 0;
            end
        end
        cyc++;
    endtask

    task automatic apply(input stim_t s);
        out_t e;
        @(posedge clk);
        #1;
        reset           = s.reset;
        if_id_rs        = s.rs;
        if_id_rt        = s.rt;
        id_uses_rt      = s.uses_rt;
        id_ex_rt        = s.ex_rt;
        id_ex_memread   = s.memread;
        id_md_op        = s.md_op;
        id_reads_hilo   = s.hilo;
        id_jump         = s.jump;
        ex_branch_taken = s.br;
        dmem_wait       = s.dwait;
        irq             = s.irq;
        model(s, e);
        sq.push_back(e);
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.reset   = ($urandom_range(0, 79) == 0);
        s.rs      = 5'($urandom_range(0, 3));
        s.rt      = 5'($urandom_range(0, 3));
        s.uses_rt = 1'($urandom_range(0, 1));
        s.ex_rt   = 5'($urandom_range(0, 3));
        s.memread = ($urandom_range(0, 2) == 0);
        s.md_op   = ($urandom_range(0, 5) == 0);
        s.hilo    = ($urandom_range(0, 4) == 0);
        s.jump    = ($urandom_range(0, 7) == 0);
        s.br      = ($urandom_range(0, 7) == 0);
        s.dwait   = ($urandom_range(0, 5) == 0);
        s.irq     = ($urandom_range(0, 19) == 0);
        return s;
    endfunction

    // Monitor: compare every presented output cycle against the queue head
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(negedge clk);
            if (sq.size() != 0) begin
                e = sq.pop_front();
                a = mk(pc_write, if_id_write, if_id_flush, id_ex_bubble,
                       ex_mem_hold, md_busy, pc_sel, irq_ack);
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL ctrl t=%0t got pcw/ifw/fl/bb/hd/busy/sel/ack=%b/%b/%b/%b/%b/%b/%b/%b required %b/%b/%b/%b/%b/%b/%b/%b",
                             $time, a.pc_write, a.if_id_write, a.if_id_flush,
                             a.id_ex_bubble, a.ex_mem_hold, a.md_busy, a.pc_sel,
                             a.irq_ack, e.pc_write, e.if_id_write, e.if_id_flush,
                             e.id_ex_bubble, e.ex_mem_hold, e.md_busy, e.pc_sel,
                             e.irq_ack);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        stim_t z;
        stim_t s;
        z = '0;
        s = z; s.reset = 1;
        apply(s);
        apply(s);
        apply(z);
        s = z; s.memread = 1; s.ex_rt = 8; s.rs = 8;
        apply(s);
        s = z; s.memread = 1; s.ex_rt = 0; s.rs = 0;
        apply(s);
        s = z; s.md_op = 1;
        apply(s);
        s = z; s.hilo = 1;
        repeat (4) apply(s);
        apply(z);
        s = z; s.br = 1; s.memread = 1; s.ex_rt = 5; s.rs = 5; s.jump = 1;
        apply(s);
        s = z; s.md_op = 1;
        apply(s);
        s = z; s.dwait = 1;
        repeat (2) apply(s);
        repeat (3) apply(z);
        s = z; s.irq = 1;
        apply(s);
        repeat (6) apply(z);
        s = z; s.irq = 1; s.md_op = 1;
        apply(s);
        repeat (7) apply(z);
        s = z; s.irq = 1;
        apply(s);
        apply(z);
        s = z; s.reset = 1;
        apply(s);
        repeat (5) apply(z);
        s = z; s.irq = 1;
        apply(s);
        s = z; s.dwait = 1;
        repeat (2) apply(s);
        repeat (6) apply(z);
        for (int i = 0; i < 3000; i++) begin
            apply(rnd());
        end
        s = z;
        repeat (12) apply(s);
        repeat (3) @(negedge clk);
        n_checks++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue got %0d pending required 0", sq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
